// File: rtl/uart_matmul_ctrl.sv
// Frame sequencer between the UART byte link and the matrix-multiply core:
// loads operands A and B, starts the multiplier, then streams the result matrix back.
module uart_matmul_ctrl #(
  parameter int         DIM         = 4,
  parameter int         DW          = 8,
  parameter int         RES_BYTES   = 2,
  parameter int         TIMEOUT_CYC = 520832,
  parameter logic [7:0] SYNC_RX     = 8'hA5,
  parameter logic [7:0] SYNC_TX     = 8'h5A,
  localparam int        AW          = (DIM * DIM > 1) ? $clog2(DIM * DIM) : 1,
  localparam int        RW          = 8 * RES_BYTES
) (
  input  logic          clk,
  input  logic          reset,
  input  logic [7:0]    rx_data,
  input  logic          rx_ready,
  output logic [7:0]    tx_data,
  output logic          tx_start,
  input  logic          tx_busy,
  output logic [AW-1:0] op_addr,
  output logic [DW-1:0] op_wdata,
  output logic          a_we,
  output logic          b_we,
  output logic          mm_start,
  input  logic          mm_done,
  output logic [AW-1:0] res_addr,
  input  logic [RW-1:0] res_rdata,
  output logic          busy,
  output logic          frame_err
);

  localparam int BW = (RES_BYTES > 1) ? $clog2(RES_BYTES) : 1;
  localparam int TW = $clog2(TIMEOUT_CYC + 1);
  localparam logic [AW-1:0] LAST = AW'(DIM * DIM - 1);

  typedef enum logic [3:0] {
    IDLE, LOAD_A, LOAD_B, START, WAIT_MM, TX_HDR, RD_RES, TX_BYTE, TX_WAIT
  } state_t;

  state_t        state;
  logic          rx_q;
  logic          rx_event;
  logic [AW-1:0] idx;
  logic [AW-1:0] ridx;
  logic [BW-1:0] bsel;
  logic [TW-1:0] tcnt;
  logic [RW-1:0] shreg;
  logic [RW-1:0] shreg_next;
  logic          rd_wait;
  logic          tx_is_hdr;

  // A level-high rx_ready only counts once, on its rising edge.
  assign rx_event   = rx_ready & ~rx_q;
  assign shreg_next = shreg << 8;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state     <= IDLE;
      rx_q      <= 1'b0;
      idx       <= '0;
      ridx      <= '0;
      bsel      <= '0;
      tcnt      <= '0;
      shreg     <= '0;
      rd_wait   <= 1'b0;
      tx_is_hdr <= 1'b0;
      tx_data   <= 8'h00;
      tx_start  <= 1'b0;
      op_addr   <= '0;
      op_wdata  <= '0;
      a_we      <= 1'b0;
      b_we      <= 1'b0;
      mm_start  <= 1'b0;
      res_addr  <= '0;
      busy      <= 1'b0;
      frame_err <= 1'b0;
    end else begin
      rx_q     <= rx_ready;
      a_we     <= 1'b0;
      b_we     <= 1'b0;
      mm_start <= 1'b0;
      case (state)
        IDLE: begin
          if (rx_event && rx_data == SYNC_RX) begin
            state     <= LOAD_A;
            idx       <= '0;
            tcnt      <= '0;
            frame_err <= 1'b0;
            busy      <= 1'b1;
          end
        end
        LOAD_A, LOAD_B: begin
          if (rx_event) begin
            tcnt     <= '0;
            op_addr  <= idx;
            op_wdata <= DW'(rx_data);
            a_we     <= (state == LOAD_A);
            b_we     <= (state == LOAD_B);
            if (idx == LAST) begin
              idx <= '0;
              if (state == LOAD_A) begin
                state <= LOAD_B;
              end else begin
                state    <= START;
                mm_start <= 1'b1;
              end
            end else begin
              idx <= idx + 1'b1;
            end
          end else if (tcnt == TW'(TIMEOUT_CYC - 1)) begin
            // Sender went silent mid-frame: abandon it, keep partial RAM contents.
            tcnt      <= '0;
            frame_err <= 1'b1;
            busy      <= 1'b0;
            state     <= IDLE;
          end else begin
            tcnt <= tcnt + 1'b1;
          end
        end
        START: state <= WAIT_MM;
        WAIT_MM: begin
          if (mm_done) begin
            state     <= TX_HDR;
            tx_data   <= SYNC_TX;
            tx_start  <= 1'b1;
            tx_is_hdr <= 1'b1;
          end
        end
        TX_HDR, TX_BYTE: begin
          if (tx_busy) begin
            tx_start <= 1'b0;
            state    <= TX_WAIT;
          end
        end
        RD_RES: begin
          // One cycle for the result RAM to return data, then latch the whole word.
          if (!rd_wait) begin
            rd_wait <= 1'b1;
          end else begin
            shreg    <= res_rdata;
            tx_data  <= res_rdata[RW-1 -: 8];
            bsel     <= BW'(RES_BYTES - 1);
            tx_start <= 1'b1;
            state    <= TX_BYTE;
          end
        end
        TX_WAIT: begin
          if (!tx_busy) begin
            if (tx_is_hdr) begin
              tx_is_hdr <= 1'b0;
              ridx      <= '0;
              res_addr  <= '0;
              rd_wait   <= 1'b0;
              state     <= RD_RES;
            end else if (bsel != '0) begin
              bsel     <= bsel - 1'b1;
              shreg    <= shreg_next;
              tx_data  <= shreg_next[RW-1 -: 8];
              tx_start <= 1'b1;
              state    <= TX_BYTE;
            end else if (ridx != LAST) begin
              ridx     <= ridx + 1'b1;
              res_addr <= ridx + 1'b1;
              rd_wait  <= 1'b0;
              state    <= RD_RES;
            end else begin
              busy  <= 1'b0;
              state <= IDLE;
            end
          end
        end
        default: begin
          state <= IDLE;
          busy  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_uart_matmul_ctrl.sv
// Randomized bench for uart_matmul_ctrl: byte-stream reference model plus
// behavioural RAM, multiplier and uart_tx stand-ins around the controller.
module tb_uart_matmul_ctrl;

  localparam int DIM = 2;
  localparam int N   = DIM * DIM;
  localparam int AW  = 2;

  typedef struct packed {
    logic [AW-1:0] addr;
    logic [7:0]    data;
  } wr_t;

  logic          clk = 1'b0;
  logic          reset;
  logic [7:0]    rx_data;
  logic          rx_ready;
  logic [7:0]    tx_data;
  logic          tx_start;
  logic          tx_busy;
  logic [AW-1:0] op_addr;
  logic [7:0]    op_wdata;
  logic          a_we;
  logic          b_we;
  logic          mm_start;
  logic          mm_done;
  logic [AW-1:0] res_addr;
  logic [15:0]   res_rdata;
  logic          busy;
  logic          frame_err;

  int checks = 0;
  int errors = 0;

  // Environment state
  logic [7:0]  ram_a [N];
  logic [7:0]  ram_b [N];
  logic [15:0] ram_c [N];
  int          mm_cnt;
  int          mm_delay;
  int          tx_delay;
  int          u_phase;
  int          u_cnt;
  logic [7:0]  u_byte;
  logic [7:0]  got_q [$];
  logic [7:0]  tx_log [$];
  logic [7:0]  g_byte;
  int          frame_bytes;

  // Reference model state
  int          mode;
  int          midx;
  logic [7:0]  ma [N];
  logic [7:0]  mb [N];
  wr_t         exp_a [$];
  wr_t         exp_b [$];
  logic [7:0]  exp_tx [$];
  int          exp_mm;
  logic        exp_err;
  logic [7:0]  fa [N];
  logic [7:0]  fb [N];
  logic [7:0]  lit_tx [9];

  uart_matmul_ctrl #(
    .DIM(DIM), .DW(8), .RES_BYTES(2), .TIMEOUT_CYC(200),
    .SYNC_RX(8'hA5), .SYNC_TX(8'h5A)
  ) dut (
    .clk(clk), .reset(reset), .rx_data(rx_data), .rx_ready(rx_ready),
    .tx_data(tx_data), .tx_start(tx_start), .tx_busy(tx_busy),
    .op_addr(op_addr), .op_wdata(op_wdata), .a_we(a_we), .b_we(b_we),
    .mm_start(mm_start), .mm_done(mm_done), .res_addr(res_addr),
    .res_rdata(res_rdata), .busy(busy), .frame_err(frame_err)
  );

  always #5 clk = ~clk;

  function automatic void check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endfunction

  function automatic void fail_now(input string name, input logic [31:0] act);
    checks++;
    errors++;
    $display("[TB] FAIL %s: got %0h expected none", name, act);
  endfunction

  function automatic logic [15:0] dot(input int i, input int j);
    int acc;
    acc = 0;
    for (int k = 0; k < DIM; k++) acc += int'(ram_a[i*DIM+k]) * int'(ram_b[k*DIM+j]);
    return 16'(acc);
  endfunction

  // Byte-level reference: what every received byte must cause.
  function automatic void model_byte(input logic [7:0] b);
    int acc;
    logic [15:0] s;
    case (mode)
      0: if (b == 8'hA5) begin mode = 1; midx = 0; exp_err = 1'b0; end
      1: begin
        ma[midx] = b;
        exp_a.push_back('{addr: AW'(midx), data: b});
        midx++;
        if (midx == N) begin mode = 2; midx = 0; end
      end
      2: begin
        mb[midx] = b;
        exp_b.push_back('{addr: AW'(midx), data: b});
        midx++;
        if (midx == N) begin
          mode = 3;
          exp_mm++;
          exp_tx.push_back(8'h5A);
          for (int i = 0; i < DIM; i++)
            for (int j = 0; j < DIM; j++) begin
              acc = 0;
              for (int k = 0; k < DIM; k++) acc += int'(ma[i*DIM+k]) * int'(mb[k*DIM+j]);
              s = 16'(acc);
              exp_tx.push_back(s[15:8]);
              exp_tx.push_back(s[7:0]);
            end
        end
      end
      default: ;
    endcase
  endfunction

  // Operand/result RAMs with one-cycle read latency
  always @(posedge clk) begin
    if (a_we) ram_a[op_addr] <= op_wdata;
    if (b_we) ram_b[op_addr] <= op_wdata;
    res_rdata <= ram_c[res_addr];
  end

  // Multiplier stand-in: computes after mm_delay cycles and pulses mm_done
  always @(posedge clk or posedge reset) begin
    if (reset) begin
      mm_done <= 1'b0;
      mm_cnt  <= 0;
    end else begin
      mm_done <= 1'b0;
      if (mm_start) mm_cnt <= mm_delay;
      else if (mm_cnt == 1) begin
        for (int i = 0; i < DIM; i++)
          for (int j = 0; j < DIM; j++) ram_c[i*DIM+j] <= dot(i, j);
        mm_done <= 1'b1;
        mm_cnt  <= 0;
      end else if (mm_cnt > 1) mm_cnt <= mm_cnt - 1;
    end
  end

  // uart_tx stand-in: takes one byte per request, busy after tx_delay cycles
  always @(posedge clk or posedge reset) begin
    if (reset) begin
      tx_busy <= 1'b0;
      u_phase <= 0;
      u_cnt   <= 0;
      u_byte  <= 8'h00;
    end else begin
      case (u_phase)
        0: if (tx_start) begin
          got_q.push_back(tx_data);
          u_byte  <= tx_data;
          u_cnt   <= tx_delay;
          u_phase <= 1;
        end
        1: if (u_cnt == 0) begin tx_busy <= 1'b1; u_cnt <= 12; u_phase <= 2; end
           else u_cnt <= u_cnt - 1;
        2: if (u_cnt == 0) begin tx_busy <= 1'b0; u_phase <= 3; end
           else u_cnt <= u_cnt - 1;
        default: u_phase <= 0;
      endcase
    end
  end

  // Compare process: DUT outputs against the reference model every cycle
  always @(negedge clk) begin
    if (!reset) begin
      if (a_we || b_we) check("we_exclusive", {31'b0, a_we & b_we}, 32'd0);
      if (a_we) begin
        if (exp_a.size() == 0) fail_now("a_we_extra", {op_addr, op_wdata});
        else check("a_write", {op_addr, op_wdata}, exp_a.pop_front());
      end
      if (b_we) begin
        if (exp_b.size() == 0) fail_now("b_we_extra", {op_addr, op_wdata});
        else check("b_write", {op_addr, op_wdata}, exp_b.pop_front());
      end
      if (mm_start) begin
        if (exp_mm == 0) fail_now("mm_start_extra", 32'd1);
        else begin checks++; exp_mm--; end
      end
      while (got_q.size() > 0) begin
        g_byte = got_q.pop_front();
        tx_log.push_back(g_byte);
        frame_bytes++;
        if (exp_tx.size() == 0) fail_now("tx_byte_extra", g_byte);
        else check("tx_byte", g_byte, exp_tx.pop_front());
      end
      if (u_phase == 1) begin
        check("tx_start_held", tx_start, 1'b1);
        check("tx_data_stable", tx_data, u_byte);
      end
    end
  end

  task automatic send_byte(input logic [7:0] b, input int hold, input int gap);
    @(posedge clk);
    #1;
    rx_data  = b;
    rx_ready = 1'b1;
    model_byte(b);
    repeat (hold) @(posedge clk);
    #1;
    rx_ready = 1'b0;
    repeat (gap) @(posedge clk);
  endtask

  task automatic send_frame(input int hmin, input int hmax, input int junk);
    logic [7:0] j;
    send_byte(8'hA5, $urandom_range(hmax, hmin), $urandom_range(40, 0));
    check("busy_after_sync", busy, 1'b1);
    check("err_cleared_by_sync", frame_err, 1'b0);
    for (int i = 0; i < N; i++) send_byte(fa[i], $urandom_range(hmax, hmin), $urandom_range(40, 0));
    for (int i = 0; i < N; i++) send_byte(fb[i], $urandom_range(hmax, hmin), $urandom_range(40, 0));
    for (int i = 0; i < junk; i++) begin
      j = 8'($urandom);
      if (j == 8'hA5) j = 8'h00;
      send_byte(j, 2, 3);
    end
  endtask

  task automatic wait_frame_done();
    int n;
    n = 0;
    while ((exp_tx.size() != 0 || busy) && n < 5000) begin
      @(posedge clk);
      n++;
    end
    #1;
    if (n >= 5000) fail_now("frame_never_finished", exp_tx.size());
    check("idle_busy", busy, 1'b0);
    check("mm_pulses_missing", exp_mm, 0);
    check("a_writes_missing", exp_a.size(), 0);
    check("b_writes_missing", exp_b.size(), 0);
    check("frame_err", frame_err, exp_err);
    mode = 0;
  endtask

  task automatic randomize_frame();
    for (int i = 0; i < N; i++) begin
      fa[i] = 8'($urandom);
      fb[i] = 8'($urandom);
    end
  endtask

  initial begin
    lit_tx = '{8'h5A, 8'h00, 8'h13, 8'h00, 8'h16, 8'h00, 8'h2B, 8'h00, 8'h32};
    rx_data = 8'h00; rx_ready = 1'b0; reset = 1'b1;
    tx_delay = 2; mm_delay = 5; mode = 0; midx = 0; exp_mm = 0; exp_err = 1'b0;
    frame_bytes = 0;
    repeat (3) @(posedge clk);
    #1;
    check("rst_tx_data", tx_data, 8'h00);
    check("rst_tx_start", tx_start, 1'b0);
    check("rst_busy", busy, 1'b0);
    check("rst_frame_err", frame_err, 1'b0);
    check("rst_strobes", {a_we, b_we, mm_start}, 3'b000);
    check("rst_addrs", {op_addr, res_addr}, 4'h0);
    @(negedge clk) reset = 1'b0;
    repeat (2) @(posedge clk);

    // Non-sync bytes are dropped while idle
    send_byte(8'h00, 2, 3);
    send_byte(8'hFF, 2, 3);
    send_byte(8'h3C, 2, 3);
    check("idle_after_junk", busy, 1'b0);

    // Known frame: [1 2;3 4] x [5 6;7 8]
    for (int i = 0; i < N; i++) begin
      fa[i] = 8'(i + 1);
      fb[i] = 8'(i + 5);
    end
    tx_log.delete();
    frame_bytes = 0;
    send_frame(1, 8, 2);
    wait_frame_done();
    check("known_byte_count", frame_bytes, 9);
    for (int i = 0; i < 9; i++) check("known_tx_literal", tx_log[i], lit_tx[i]);
    for (int i = 0; i < N; i++) begin
      check("known_ram_a", ram_a[i], 8'(i + 1));
      check("known_ram_b", ram_b[i], 8'(i + 5));
    end

    // rx_ready held high for 50 cycles per byte
    randomize_frame();
    frame_bytes = 0;
    send_frame(50, 50, 0);
    wait_frame_done();
    check("hold50_byte_count", frame_bytes, 9);

    // Slow uart_tx: busy appears 30 cycles after each request
    tx_delay = 30;
    randomize_frame();
    frame_bytes = 0;
    send_frame(1, 10, 1);
    wait_frame_done();
    check("slow_tx_byte_count", frame_bytes, 9);
    tx_delay = 2;

    // Timeout partway through A
    send_byte(8'hA5, 3, 5);
    send_byte(8'h01, 3, 5);
    send_byte(8'h02, 3, 0);
    repeat (190) @(posedge clk);
    #1;
    check("pre_timeout_err", frame_err, 1'b0);
    check("pre_timeout_busy", busy, 1'b1);
    repeat (10) @(posedge clk);
    #1;
    mode = 0;
    exp_err = 1'b1;
    check("timeout_err", frame_err, 1'b1);
    check("timeout_busy", busy, 1'b0);
    check("timeout_writes_left", exp_a.size(), 0);
    randomize_frame();
    frame_bytes = 0;
    send_frame(1, 6, 0);
    wait_frame_done();
    check("after_timeout_bytes", frame_bytes, 9);

    // Random frames
    for (int f = 0; f < 4; f++) begin
      tx_delay = $urandom_range(30, 0);
      mm_delay = $urandom_range(20, 1);
      randomize_frame();
      frame_bytes = 0;
      send_frame(1, 40, $urandom_range(3, 0));
      wait_frame_done();
      check("rand_byte_count", frame_bytes, 9);
    end

    // Reset while the third result byte is being requested
    tx_delay = 15;
    randomize_frame();
    frame_bytes = 0;
    send_frame(1, 5, 0);
    begin
      int n;
      n = 0;
      while (frame_bytes < 4 && n < 5000) begin
        @(negedge clk);
        n++;
      end
      if (n >= 5000) fail_now("reset_point_not_reached", frame_bytes);
    end
    check("start_before_reset", tx_start, 1'b1);
    #2 reset = 1'b1;
    #1;
    check("midrst_tx_start", tx_start, 1'b0);
    check("midrst_busy", busy, 1'b0);
    check("midrst_tx_data", tx_data, 8'h00);
    check("midrst_strobes", {a_we, b_we, mm_start}, 3'b000);
    exp_a.delete(); exp_b.delete(); exp_tx.delete(); got_q.delete();
    exp_mm = 0; mode = 0; exp_err = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk) reset = 1'b0;
    tx_delay = 4;
    randomize_frame();
    frame_bytes = 0;
    send_frame(1, 10, 1);
    wait_frame_done();
    check("post_reset_bytes", frame_bytes, 9);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
